// File: rtl/seven_seg_scan_if.sv
// Bus between a display-data producer and the seven_seg_scan multiplexer.
// The producer loads hold data; the scanner returns digit/anode/dp/frame.
interface seven_seg_scan_if #(
  parameter int NDIGITS = 8
);
  logic                   load;
  logic [4*NDIGITS-1:0]   value;
  logic [NDIGITS-1:0]     dp_in;
  logic [NDIGITS-1:0]     blank;
  logic [3:0]             digit;
  logic [NDIGITS-1:0]     an_n;
  logic                   dp_n;
  logic                   frame;

  modport master (
    output load, value, dp_in, blank,
    input  digit, an_n, dp_n, frame
  );

  modport slave (
    input  load, value, dp_in, blank,
    output digit, an_n, dp_n, frame
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner with per-slot anode guard time.
// Define SEVEN_SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seven_seg_scan #(
  parameter int NDIGITS = 8,
  parameter int DIV     = 100000,
  parameter int GUARD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  seven_seg_scan_if.slave  bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [IW-1:0]          idx_reg, idx_next;
  logic [4*NDIGITS-1:0]   hold_value_reg, hold_value_next;
  logic [NDIGITS-1:0]     hold_dp_reg, hold_dp_next;
  logic [NDIGITS-1:0]     hold_blank_reg, hold_blank_next;

  logic [3:0]             digit_reg, digit_next;
  logic [NDIGITS-1:0]     an_n_reg, an_n_next;
  logic                   dp_n_reg, dp_n_next;
  logic                   frame_reg, frame_next;

  logic [NDIGITS-1:0]     lzb_blank;
  logic [NDIGITS-1:0]     digit_off;
  logic                   slot_end;

  assign slot_end = (cnt_reg == CW'(DIV - 1));

  always_comb begin
    cnt_next        = slot_end ? '0 : cnt_reg + CW'(1);
    idx_next        = idx_reg;
    if (slot_end)
      idx_next = (idx_reg == IW'(NDIGITS - 1)) ? '0 : idx_reg + IW'(1);
    hold_value_next = bus.load ? bus.value : hold_value_reg;
    hold_dp_next    = bus.load ? bus.dp_in : hold_dp_reg;
    hold_blank_next = bus.load ? bus.blank : hold_blank_reg;
  end

  // Leading-zero detection on the post-load hold value so a load and its
  // blanking effect appear together.
  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_lzb
`ifdef SEVEN_SEG_SCAN_LZB_EN
      if (gi == 0) begin : g_first
        assign lzb_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lzb_blank[gi] = (hold_value_next[4*NDIGITS-1:4*gi] == '0);
      end
`else
      assign lzb_blank[gi] = 1'b0;
`endif
      assign digit_off[gi] = hold_blank_next[gi] | lzb_blank[gi];
    end
  endgenerate

  // Outputs are registered from next-state values, so they always
  // describe the current cnt/idx/hold contents.
  always_comb begin
    digit_next = 4'h0;
    an_n_next  = '1;
    dp_n_next  = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_next == IW'(i)) begin
        digit_next = hold_value_next[4*i +: 4];
        if ((cnt_next >= CW'(GUARD)) && !digit_off[i]) begin
          an_n_next[i] = 1'b0;
          dp_n_next    = ~hold_dp_next[i];
        end
      end
    end
    frame_next = (cnt_next == '0) && (idx_next == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      hold_value_reg <= '0;
      hold_dp_reg    <= '0;
      hold_blank_reg <= '1;
      digit_reg      <= 4'h0;
      an_n_reg       <= '1;
      dp_n_reg       <= 1'b1;
      frame_reg      <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      hold_value_reg <= hold_value_next;
      hold_dp_reg    <= hold_dp_next;
      hold_blank_reg <= hold_blank_next;
      digit_reg      <= digit_next;
      an_n_reg       <= an_n_next;
      dp_n_reg       <= dp_n_next;
      frame_reg      <= frame_next;
    end
  end

  assign bus.digit = digit_reg;
  assign bus.an_n  = an_n_reg;
  assign bus.dp_n  = dp_n_reg;
  assign bus.frame = frame_reg;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized bench for seven_seg_scan against a time-indexed scan model.
// Honours SEVEN_SEG_SCAN_LZB_EN the same way the design does.
module tb_seven_seg_scan;
  localparam int N = 4;
  localparam int D = 4;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_if #(.NDIGITS(N)) bus ();

  seven_seg_scan #(.NDIGITS(N), .DIV(D), .GUARD(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int errors  = 0;
  int t;
  logic [4*N-1:0] m_val;
  logic [N-1:0]   m_dp;
  logic [N-1:0]   m_blank;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    m_val   = '0;
    m_dp    = '0;
    m_blank = '1;
  endtask

  // Expected outputs from elapsed cycles since reset and the loaded data.
  task automatic check_model();
    int cnt, idx;
    logic off, active;
    logic [N-1:0] exp_an;
    cnt = t % D;
    idx = (t / D) % N;
    off = m_blank[idx];
`ifdef SEVEN_SEG_SCAN_LZB_EN
    if (idx > 0 && (m_val >> (4 * idx)) == 0) off = 1'b1;
`endif
    active = (cnt >= G) && !off;
    exp_an = '1;
    if (active) exp_an[idx] = 1'b0;
    cmp("digit", 32'(bus.digit), 32'((m_val >> (4 * idx)) & 4'hF));
    cmp("an_n",  32'(bus.an_n), 32'(exp_an));
    cmp("dp_n",  32'(bus.dp_n), 32'(!(active && m_dp[idx])));
    cmp("frame", 32'(bus.frame), 32'(t > 0 && (t % (D * N)) == 0));
  endtask

  // Called at a falling edge: check, drive, clock, update model.
  task automatic step(input logic l, input logic [4*N-1:0] v,
                      input logic [N-1:0] dp, input logic [N-1:0] bl);
    check_model();
    bus.load  = l;
    bus.value = v;
    bus.dp_in = dp;
    bus.blank = bl;
    @(posedge clk);
    if (l) begin
      m_val   = v;
      m_dp    = dp;
      m_blank = bl;
    end
    t++;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic idle_to(input int target);
    while (t < target) step(1'b0, '0, '0, '0);
  endtask

  initial begin
    logic [4*N-1:0] rv;
    logic [N-1:0]   rb;
    int nz;
    bus.load  = 1'b0;
    bus.value = '0;
    bus.dp_in = '0;
    bus.blank = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();

    cmp("rst_digit", 32'(bus.digit), 32'h0);
    cmp("rst_an_n",  32'(bus.an_n), 32'hF);
    cmp("rst_dp_n",  32'(bus.dp_n), 32'h1);
    cmp("rst_frame", 32'(bus.frame), 32'h0);

    step(1'b1, 16'h1234, 4'b0100, 4'b0000);
    cmp("lit_t1_digit", 32'(bus.digit), 32'h4);
    cmp("lit_t1_an_n",  32'(bus.an_n), 32'hE);
    idle_to(8);
    cmp("lit_guard_an_n",  32'(bus.an_n), 32'hF);
    cmp("lit_guard_digit", 32'(bus.digit), 32'h2);
    cmp("lit_guard_dp_n",  32'(bus.dp_n), 32'h1);
    idle_to(9);
    cmp("lit_idx2_an_n", 32'(bus.an_n), 32'hB);
    cmp("lit_idx2_dp_n", 32'(bus.dp_n), 32'h0);
    idle_to(16);
    cmp("lit_frame", 32'(bus.frame), 32'h1);

    step(1'b1, 16'h0000, 4'b0000, 4'b0000);
    idle_to(22);
    step(1'b1, 16'hABCD, 4'b0000, 4'b0000);
    cmp("lit_midslot_digit", 32'(bus.digit), 32'hC);
    cmp("lit_midslot_an_n",  32'(bus.an_n), 32'hD);

    idle_to(27);
    step(1'b1, 16'h5678, 4'b1111, 4'b0000);
    cmp("lit_adv_digit", 32'(bus.digit), 32'h5);
    cmp("lit_adv_an_n",  32'(bus.an_n), 32'hF);
    cmp("lit_adv_dp_n",  32'(bus.dp_n), 32'h1);

    step(1'b1, 16'h0050, 4'b0000, 4'b0000);
`ifdef SEVEN_SEG_SCAN_LZB_EN
    cmp("lit_lzb_idx3", 32'(bus.an_n), 32'hF);
`else
    cmp("lit_lzb_idx3", 32'(bus.an_n), 32'h7);
`endif
    idle_to(33);
    cmp("lit_lzb_idx0_digit", 32'(bus.digit), 32'h0);
    cmp("lit_lzb_idx0_an_n",  32'(bus.an_n), 32'hE);
    idle_to(37);
    cmp("lit_lzb_idx1_digit", 32'(bus.digit), 32'h5);
    cmp("lit_lzb_idx1_an_n",  32'(bus.an_n), 32'hD);

    // Asynchronous reset pulse in the middle of an active slot.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("arst_digit", 32'(bus.digit), 32'h0);
    cmp("arst_an_n",  32'(bus.an_n), 32'hF);
    cmp("arst_dp_n",  32'(bus.dp_n), 32'h1);
    cmp("arst_frame", 32'(bus.frame), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle_to(6);

    for (int k = 0; k < 500; k++) begin
      rv = 16'($urandom);
      nz = $urandom_range(0, N);
      rv = rv & 16'((32'h1 << (4 * nz)) - 1);
      rb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      step($urandom_range(0, 3) == 0, rv, 4'($urandom), rb);
    end
    check_model();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
